// File: rtl/rle_mask_decoder.sv
// rle_mask_decoder
// Expands run-length tokens into a raster-ordered binary mask stream, one
// pixel per output handshake, while tracking x/y position and flagging runs
// that cross a line end.
//
// Ports:
//   CLK          system clock, rising edge
//   reset_n      synchronous active-low reset
//   tok_valid    token present
//   tok_ready    token accepted when tok_valid && tok_ready
//   tok_bit      mask value of the run
//   tok_len      run length minus one
//   tok_eol      run is last of its line; rest of line padded with 0
//   pix_valid    pixel present
//   pix_ready    pixel consumed when pix_valid && pix_ready
//   pix_bit      mask value
//   pix_sof      pixel is x=0, y=0
//   pix_eol      pixel is x=WIDTH-1
//   pix_eof      pixel is x=WIDTH-1, y=HEIGHT-1
//   frame_done   one-cycle pulse after the last pixel of a frame is consumed
//   err_overrun  sticky: a run crossed a line end
module rle_mask_decoder #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int LEN_W  = 10
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_bit,
  input  logic [LEN_W-1:0] tok_len,
  input  logic             tok_eol,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_bit,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic             pix_eof,
  output logic             frame_done,
  output logic             err_overrun
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PAD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [LEN_W-1:0] r_remaining;
  logic             r_run_bit;
  logic             r_eol_flag;
  logic             r_frame_done;
  logic             r_err_overrun;

  logic w_last_x;
  logic w_last_y;
  logic w_rem_zero;
  logic w_pix_fire;
  logic w_tok_ready;
  logic w_pix_valid;
  logic w_pix_bit;
  logic w_load;
  logic w_dec;
  logic w_overrun;

  assign w_last_x   = (r_x == X_LAST);
  assign w_last_y   = (r_y == Y_LAST);
  assign w_rem_zero = (r_remaining == {LEN_W{1'b0}});
  assign w_pix_fire = w_pix_valid && pix_ready;

  // Next-state, handshake and pixel-value decode.
  always_comb begin
    w_state_nxt = r_state;
    w_tok_ready = 1'b0;
    w_pix_valid = 1'b0;
    w_pix_bit   = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tok_ready = 1'b1;
        if (tok_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_pix_valid = 1'b1;
        w_pix_bit   = r_run_bit;
        if (!w_rem_zero) begin
          // Run still has pixels left; hitting the line end truncates it.
          if (pix_ready && w_last_x) begin
            w_overrun   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (pix_ready) begin
            w_dec = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else if (r_eol_flag && !w_last_x) begin
          if (pix_ready) begin
            w_state_nxt = ST_PAD;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          // Last pixel of a complete run: chain the next token with no bubble.
          w_tok_ready = pix_ready;
          if (pix_ready && tok_valid) begin
            w_load      = 1'b1;
            w_state_nxt = ST_RUN;
          end else if (pix_ready) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_PAD: begin
        w_pix_valid = 1'b1;
        if (pix_ready && w_last_x) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_PAD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Loaded run: bit value, pixels left after the current one, eol request.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_run_bit   <= 1'b0;
      r_remaining <= {LEN_W{1'b0}};
      r_eol_flag  <= 1'b0;
    end else if (w_load) begin
      r_run_bit   <= tok_bit;
      r_remaining <= tok_len;
      r_eol_flag  <= tok_eol;
    end else if (w_dec) begin
      r_remaining <= r_remaining - LEN_W'(1);
    end
  end

  // Raster position, advanced on every consumed pixel.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_x <= {XW{1'b0}};
      r_y <= {YW{1'b0}};
    end else if (w_pix_fire) begin
      if (w_last_x) begin
        r_x <= {XW{1'b0}};
        r_y <= w_last_y ? {YW{1'b0}} : (r_y + YW'(1));
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  // End-of-frame pulse and sticky overrun flag.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_frame_done  <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_frame_done <= w_pix_fire && w_last_x && w_last_y;
      if (w_overrun) begin
        r_err_overrun <= 1'b1;
      end
    end
  end

  assign tok_ready   = w_tok_ready;
  assign pix_valid   = w_pix_valid;
  assign pix_bit     = w_pix_bit;
  assign pix_sof     = w_pix_valid && (r_x == {XW{1'b0}}) && (r_y == {YW{1'b0}});
  assign pix_eol     = w_pix_valid && w_last_x;
  assign pix_eof     = w_pix_valid && w_last_x && w_last_y;
  assign frame_done  = r_frame_done;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_rle_mask_decoder.sv
// Bench for rle_mask_decoder at WIDTH=8, HEIGHT=2. Accepted tokens are
// expanded by a reference model into a queue of expected pixels (value and
// sof/eol/eof flags from a running frame position); every DUT pixel
// handshake is compared against the head of that queue.
module tb_rle_mask_decoder;

  localparam int W  = 8;
  localparam int H  = 2;
  localparam int LW = 10;

  logic          CLK = 1'b0;
  logic          reset_n;
  logic          tok_valid;
  logic          tok_ready;
  logic          tok_bit;
  logic [LW-1:0] tok_len;
  logic          tok_eol;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_bit;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;
  logic          frame_done;
  logic          err_overrun;

  always #5 CLK = ~CLK;

  rle_mask_decoder #(.WIDTH(W), .HEIGHT(H), .LEN_W(LW)) dut (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .tok_valid   (tok_valid),
    .tok_ready   (tok_ready),
    .tok_bit     (tok_bit),
    .tok_len     (tok_len),
    .tok_eol     (tok_eol),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_bit     (pix_bit),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .pix_eof     (pix_eof),
    .frame_done  (frame_done),
    .err_overrun (err_overrun)
  );

  typedef struct {
    logic          b;
    logic [LW-1:0] len;
    logic          eol;
  } tok_t;

  // chain: last pixel of a naturally complete run (next token may load).
  // ovr:   last pixel emitted from a run truncated at the line end.
  typedef struct {
    logic b;
    logic sof;
    logic eol;
    logic eof;
    logic chain;
    logic ovr;
  } px_t;

  tok_t stim_q[$];
  px_t  exp_q[$];
  int   wpos;
  logic err_exp;
  logic fd_exp;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_px(input logic b, input logic chain, input logic ovr);
    px_t p;
    p.b     = b;
    p.sof   = (wpos == 0);
    p.eol   = ((wpos % W) == W - 1);
    p.eof   = (wpos == W * H - 1);
    p.chain = chain;
    p.ovr   = ovr;
    exp_q.push_back(p);
    wpos = (wpos + 1) % (W * H);
  endtask

  // Expand one accepted token starting at the current model position.
  task automatic expand(input logic b, input int len, input logic eol);
    int room;
    int L;
    int n;
    int pad;
    room = W - (wpos % W);
    L    = len + 1;
    n    = (L < room) ? L : room;
    pad  = (eol && (L < room)) ? (room - L) : 0;
    for (int i = 0; i < n; i++) begin
      push_px(b, (i == n - 1) && (L <= room) && (pad == 0), (i == n - 1) && (L > room));
    end
    for (int i = 0; i < pad; i++) begin
      push_px(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic add_tok(input logic b, input int len, input logic eol);
    tok_t t;
    t.b   = b;
    t.len = LW'(len);
    t.eol = eol;
    stim_q.push_back(t);
  endtask

  // One clock: drive at the falling edge, check, then account handshakes.
  task automatic step(input logic rdy, input logic offer);
    logic exp_tr;
    logic pf;
    logic tf;
    px_t  p;
    @(negedge CLK);
    pix_ready = rdy;
    if (offer && stim_q.size() > 0) begin
      tok_valid = 1'b1;
      tok_bit   = stim_q[0].b;
      tok_len   = stim_q[0].len;
      tok_eol   = stim_q[0].eol;
    end else begin
      tok_valid = 1'b0;
      tok_bit   = 1'b0;
      tok_len   = '0;
      tok_eol   = 1'b0;
    end
    #1;
    check_eq("pix_valid", pix_valid, exp_q.size() > 0);
    check_eq("frame_done", frame_done, fd_exp);
    check_eq("err_overrun", err_overrun, err_exp);
    exp_tr = (exp_q.size() == 0) || ((exp_q.size() == 1) && exp_q[0].chain && rdy);
    check_eq("tok_ready", tok_ready, exp_tr);
    if (pix_valid && exp_q.size() > 0) begin
      check_eq("pix_bit", pix_bit, exp_q[0].b);
      check_eq("pix_sof", pix_sof, exp_q[0].sof);
      check_eq("pix_eol", pix_eol, exp_q[0].eol);
      check_eq("pix_eof", pix_eof, exp_q[0].eof);
    end else begin
      check_eq("idle_flags", {pix_sof, pix_eol, pix_eof}, 3'b000);
    end
    pf     = pix_valid && rdy;
    tf     = tok_valid && tok_ready;
    fd_exp = 1'b0;
    if (pf && exp_q.size() > 0) begin
      p      = exp_q.pop_front();
      fd_exp = p.eof;
      if (p.ovr) begin
        err_exp = 1'b1;
      end
    end
    if (tf) begin
      expand(stim_q[0].b, int'(stim_q[0].len), stim_q[0].eol);
      void'(stim_q.pop_front());
    end
  endtask

  task automatic drain(input logic rand_ready);
    int budget;
    budget = 4000;
    while ((exp_q.size() > 0 || stim_q.size() > 0) && budget > 0) begin
      step(rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b1);
      budget--;
    end
    if (budget == 0) begin
      check_eq("drain_timeout", 32'd0, 32'd1);
    end
    // A few idle cycles so the last frame_done pulse is observed.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    reset_n   = 1'b0;
    tok_valid = 1'b0;
    pix_ready = 1'($urandom_range(0, 1));
    repeat (cycles) @(negedge CLK);
    reset_n = 1'b1;
    #1;
    check_eq("rst_pix_valid", pix_valid, 1'b0);
    check_eq("rst_tok_ready", tok_ready, 1'b1);
    check_eq("rst_err", err_overrun, 1'b0);
    check_eq("rst_frame_done", frame_done, 1'b0);
    check_eq("rst_pix_bits", {pix_bit, pix_sof, pix_eol, pix_eof}, 4'b0000);
    exp_q.delete();
    wpos    = 0;
    err_exp = 1'b0;
    fd_exp  = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    tok_valid = 1'b0;
    tok_bit   = 1'b0;
    tok_len   = '0;
    tok_eol   = 1'b0;
    pix_ready = 1'b0;
    wpos      = 0;
    err_exp   = 1'b0;
    fd_exp    = 1'b0;
    do_reset(3);

    // Line fill: 3 ones then 5 zeros, no bubbles.
    add_tok(1'b1, 2, 1'b0);
    add_tok(1'b0, 4, 1'b0);
    drain(1'b0);

    // Short eol pad on line 1, then fill it back to frame start.
    add_tok(1'b1, 1, 1'b1);
    add_tok(1'b1, 7, 1'b0);
    drain(1'b0);

    // Overrun at x=6 with a 5-pixel run; next token at x=0 of next line.
    add_tok(1'b0, 5, 1'b0);
    add_tok(1'b1, 4, 1'b0);
    add_tok(1'b1, 0, 1'b0);
    add_tok(1'b0, 6, 1'b0);
    drain(1'b0);

    // Backpressure 1,0,0,1 during a 4-pixel run.
    do_reset(1);
    add_tok(1'b1, 3, 1'b0);
    add_tok(1'b0, 3, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    drain(1'b0);

    // Frame wrap: 16 pixels, then pixel 17 must be start of frame.
    do_reset(1);
    add_tok(1'b1, 7, 1'b0);
    add_tok(1'b0, 3, 1'b1);
    add_tok(1'b1, 0, 1'b0);
    drain(1'b0);

    // Reset mid-run while pixels remain in the loaded run.
    add_tok(1'b1, 6, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    do_reset(1);
    add_tok(1'b0, 2, 1'b0);
    drain(1'b0);

    // Randomized traffic with random backpressure and occasional resets.
    for (int i = 0; i < 2500; i++) begin
      if (stim_q.size() == 0) begin
        add_tok(1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 9)),
                1'($urandom_range(0, 3) == 0));
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      if ((i % 600) == 599) begin
        do_reset(1);
      end
    end
    drain(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
